debounce_scheduler: RTL and testbench



---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_scheduler_if.sv | 34 +++
 rtl/event_rr_arb.sv | 38 +++
 rtl/debounce_scheduler.sv | 160 ++++++++++++++++
 tb/tb_debounce_scheduler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types, defaults and width helper for the debounce scheduler
// Purpose : event FSM state type, default tick/sample constants, index-width function.
// Ports   : none (package).
package debounce_pkg;

    localparam int N_SW_DEF     = 4;
    localparam int SAMPLES_DEF  = 4;
    localparam int TICK_DIV_DEF = 50000;   // 50 MHz system clock -> 1 ms sample tick

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } ev_state_t;

    // Index width for n items; never less than one bit so a single switch still has an id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// rtl/debounce_scheduler_if.sv - event handshake bundle between scheduler and consumer
// Purpose : groups the valid/ack event channel and the sticky overrun flag.
// Ports   : master = scheduler side (drives EvValid/EvId/EvLevel/EvOverrun, takes EvAck)
//           slave  = consumer side (takes the event, drives EvAck)
interface debounce_scheduler_if #(
    parameter int N_SW = 4
);
    import debounce_pkg::*;

    localparam int ID_W = id_width(N_SW);

    logic            EvValid;
    logic [ID_W-1:0] EvId;
    logic            EvLevel;
    logic            EvAck;
    logic            EvOverrun;

    modport master (
        output EvValid,
        output EvId,
        output EvLevel,
        output EvOverrun,
        input  EvAck
    );

    modport slave (
        input  EvValid,
        input  EvId,
        input  EvLevel,
        input  EvOverrun,
        output EvAck
    );

endinterface

// File: rtl/event_rr_arb.sv
// rtl/event_rr_arb.sv - combinational round-robin select over pending switch events
// Purpose : picks the first set pend bit at or after rr_ptr, wrapping past N_SW-1.
// Ports   : pend    - pending-event bits, one per switch
//           rr_ptr  - search start index (always < N_SW)
//           grant   - index of the selected switch (0 when nothing pending)
//           any_req - at least one pend bit set
module event_rr_arb
    import debounce_pkg::*;
#(
    parameter int N_SW = 4,
    parameter int ID_W = id_width(N_SW)
) (
    input  logic [N_SW-1:0] pend,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [ID_W-1:0] grant,
    output logic            any_req
);

    always_comb begin : sel
        int   j;
        logic found;
        grant   = '0;
        any_req = |pend;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N_SW; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_SW) begin
                j = j - N_SW;
            end
            if (!found && pend[j]) begin
                found = 1'b1;
                grant = j[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - multi-switch 4-of-4 debouncer with round-robin event delivery
// Purpose : synchronises N_SW switches, samples them on a divided tick, filters each with
//           all-agree history, queues level changes and hands them out one at a time.
// Ports   : Clk, Rst  - clock, synchronous active-high reset
//           Enable    - 0 freezes tick counter, histories and debounced levels
//           SwIn      - raw switch levels
//           SwOutDB   - debounced levels
//           Tick      - one-cycle pulse at each sample instant
//           ev        - event channel (EvValid/EvId/EvLevel/EvAck/EvOverrun)
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N_SW     = N_SW_DEF,
    parameter int SAMPLES  = SAMPLES_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Enable,
    input  logic [N_SW-1:0]       SwIn,
    output logic [N_SW-1:0]       SwOutDB,
    output logic                  Tick,
    debounce_scheduler_if.master  ev
);

    localparam int ID_W  = id_width(N_SW);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [N_SW-1:0]    sync_q1;
    logic [N_SW-1:0]    sync_q2;
    logic [CNT_W-1:0]   tick_cnt;
    logic [SAMPLES-1:0] hist [N_SW];
    logic [N_SW-1:0]    db_next;
    logic [N_SW-1:0]    chg;
    logic [N_SW-1:0]    clr;
    logic [N_SW-1:0]    pend;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    ev_id;
    logic               any_req;
    logic               ev_valid;
    logic               overrun;
    ev_state_t          state;

    // Two-flop synchroniser; reset so nothing stale survives a mid-run reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= SwIn;
            sync_q2 <= sync_q1;
        end
    end

    // Tick is decoded from the counter so it lines up with the wrap cycle exactly.
    assign Tick = Enable && (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            tick_cnt <= '0;
        end else if (Enable) begin
            tick_cnt <= Tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // Decision uses the history before this tick's shift, giving SAMPLES+1 ticks of latency.
    always_comb begin
        db_next = SwOutDB;
        for (int i = 0; i < N_SW; i++) begin
            if (&hist[i]) begin
                db_next[i] = 1'b1;
            end else if (~|hist[i]) begin
                db_next[i] = 1'b0;
            end
        end
    end

    assign chg = Tick ? (db_next ^ SwOutDB) : '0;

    always_comb begin
        clr = '0;
        if (state == ST_PRESENT && ev.EvAck) begin
            clr[ev_id] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < N_SW; i++) begin
                hist[i] <= '0;
            end
            SwOutDB <= '0;
        end else if (Tick) begin
            for (int i = 0; i < N_SW; i++) begin
                hist[i] <= {hist[i][SAMPLES-2:0], sync_q2[i]};
            end
            SwOutDB <= db_next;
        end
    end

    // A new change beats an ack on the same switch; overrun only when the old event is
    // still outstanding and not being retired this cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pend    <= '0;
            overrun <= 1'b0;
        end else begin
            pend    <= (pend & ~clr) | chg;
            overrun <= overrun | (|(chg & pend & ~clr));
        end
    end

    event_rr_arb #(
        .N_SW (N_SW),
        .ID_W (ID_W)
    ) u_arb (
        .pend    (pend),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            ev_valid <= 1'b0;
            ev_id    <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        ev_id    <= grant;
                        ev_valid <= 1'b1;
                        state    <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ev.EvAck) begin
                        ev_valid <= 1'b0;
                        rr_ptr   <= (ev_id == ID_W'(N_SW - 1)) ? '0 : ev_id + 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ev_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ev.EvValid   = ev_valid;
    assign ev.EvId      = ev_id;
    // Live level of the presented switch so the consumer sees any change made since grant.
    assign ev.EvLevel   = ev_valid & SwOutDB[ev_id];
    assign ev.EvOverrun = overrun;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - directed bench for debounce_scheduler
module tb_debounce_scheduler;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Enable;
    logic [3:0] SwIn;
    logic [3:0] SwOutDB;
    logic       Tick;

    debounce_scheduler_if #(.N_SW(4)) ev_if ();

    debounce_scheduler #(
        .N_SW     (4),
        .SAMPLES  (4),
        .TICK_DIV (4)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Enable  (Enable),
        .SwIn    (SwIn),
        .SwOutDB (SwOutDB),
        .Tick    (Tick),
        .ev      (ev_if)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (ev_if.EvValid) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    bit s4_valid [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int s4_id    [7] = '{0, 0, 1, 0, 3, 0, 0};

    initial begin
        int  ticks;
        int  last_tick;
        int  bad_gap;
        int  seen_valid;
        int  db_bad;
        bit  ok;

        Rst          = 1'b1;
        Enable       = 1'b1;
        SwIn         = 4'b0000;
        ev_if.EvAck  = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("rst_swoutdb", 32'(SwOutDB), 0);
        chk("rst_tick", 32'(Tick), 0);
        chk("rst_evvalid", 32'(ev_if.EvValid), 0);
        chk("rst_evid", 32'(ev_if.EvId), 0);
        chk("rst_evlevel", 32'(ev_if.EvLevel), 0);
        chk("rst_overrun", 32'(ev_if.EvOverrun), 0);
        Rst = 1'b0;

        // 1: idle inputs, tick every 4th cycle
        ticks = 0; last_tick = 0; bad_gap = 0; seen_valid = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (Tick) begin
                if (ticks > 0 && (c - last_tick) != 4) bad_gap++;
                ticks++;
                last_tick = c;
            end
            if (ev_if.EvValid) seen_valid++;
        end
        chk("s1_tick_count", 32'(ticks), 10);
        chk("s1_tick_gap", 32'(bad_gap), 0);
        chk("s1_no_event", 32'(seen_valid), 0);
        chk("s1_swoutdb", 32'(SwOutDB), 0);

        // 2: single rising switch, count ticks after the synchronised edge
        SwIn[2] = 1'b1;
        cyc();
        cyc();
        ticks = 0; ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (SwOutDB[2]) begin
                ok = 1'b1;
                break;
            end
            if (Tick) ticks++;
            cyc();
        end
        chk("s2_rise_seen", 32'(ok), 1);
        chk("s2_ticks_to_rise", 32'(ticks), 5);
        chk("s2_valid_not_yet", 32'(ev_if.EvValid), 0);
        cyc();
        chk("s2_valid", 32'(ev_if.EvValid), 1);
        chk("s2_id", 32'(ev_if.EvId), 2);
        chk("s2_level", 32'(ev_if.EvLevel), 1);
        ev_if.EvAck = 1'b1;
        cyc();
        ev_if.EvAck = 1'b0;
        chk("s2_valid_after_ack", 32'(ev_if.EvValid), 0);
        cyc();
        chk("s2_valid_stays_low", 32'(ev_if.EvValid), 0);

        // 3: bouncing switch 1 must never settle or raise an event
        db_bad = 0; seen_valid = 0;
        for (int c = 0; c < 60; c++) begin
            if (c % 6 == 0) SwIn[1] = ~SwIn[1];
            cyc();
            if (SwOutDB[1]) db_bad++;
            if (ev_if.EvValid) seen_valid++;
        end
        chk("s3_db1_low", 32'(db_bad), 0);
        chk("s3_no_event", 32'(seen_valid), 0);

        // 4: simultaneous changes on 0,1,3 with ack held; fresh reset puts rr_ptr at 0
        SwIn = 4'b0000;
        Rst  = 1'b1;
        cyc();
        cyc();
        Rst  = 1'b0;
        SwIn = 4'b1011;
        ev_if.EvAck = 1'b1;
        wait_valid(200, ok);
        chk("s4_first_valid", 32'(ok), 1);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("s4_valid_%0d", i), 32'(ev_if.EvValid), 32'(s4_valid[i]));
            if (s4_valid[i]) begin
                chk($sformatf("s4_id_%0d", i), 32'(ev_if.EvId), 32'(s4_id[i]));
                chk($sformatf("s4_level_%0d", i), 32'(ev_if.EvLevel), 1);
            end
            cyc();
        end
        ev_if.EvAck = 1'b0;
        chk("s4_swoutdb", 32'(SwOutDB), 32'hb);

        // 5: unacked event on switch 0 then switch 0 changes back -> overrun, live level
        SwIn = 4'b1010;
        wait_valid(200, ok);
        chk("s5_valid", 32'(ok), 1);
        chk("s5_id", 32'(ev_if.EvId), 0);
        chk("s5_level_low", 32'(ev_if.EvLevel), 0);
        chk("s5_no_overrun_yet", 32'(ev_if.EvOverrun), 0);
        SwIn = 4'b1011;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (SwOutDB[0]) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        chk("s5_relevel_seen", 32'(ok), 1);
        chk("s5_level_live", 32'(ev_if.EvLevel), 1);
        chk("s5_overrun", 32'(ev_if.EvOverrun), 1);
        chk("s5_still_valid", 32'(ev_if.EvValid), 1);
        chk("s5_id_stable", 32'(ev_if.EvId), 0);
        ev_if.EvAck = 1'b1;
        cyc();
        ev_if.EvAck = 1'b0;
        chk("s5_valid_after_ack", 32'(ev_if.EvValid), 0);
        chk("s5_overrun_sticky", 32'(ev_if.EvOverrun), 1);
        cyc();
        cyc();
        chk("s5_drained", 32'(ev_if.EvValid), 0);

        // 6: Enable low freezes everything; then reset while an event is presented
        Enable = 1'b0;
        SwIn   = 4'b0100;
        ticks = 0; db_bad = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (Tick) ticks++;
            if (SwOutDB !== 4'b1011) db_bad++;
        end
        chk("s6_no_tick", 32'(ticks), 0);
        chk("s6_db_frozen", 32'(db_bad), 0);
        Enable = 1'b1;
        wait_valid(200, ok);
        chk("s6_valid_before_rst", 32'(ok), 1);
        SwIn = 4'b0000;
        Rst  = 1'b1;
        cyc();
        chk("s6_rst_swoutdb", 32'(SwOutDB), 0);
        chk("s6_rst_tick", 32'(Tick), 0);
        chk("s6_rst_valid", 32'(ev_if.EvValid), 0);
        chk("s6_rst_id", 32'(ev_if.EvId), 0);
        chk("s6_rst_level", 32'(ev_if.EvLevel), 0);
        chk("s6_rst_overrun", 32'(ev_if.EvOverrun), 0);
        Rst = 1'b0;
        seen_valid = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (ev_if.EvValid) seen_valid++;
        end
        chk("s6_pending_discarded", 32'(seen_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
